// File: rtl/dmem_responder.sv
// Word-organised data-memory slave with a req/ack handshake, programmable wait
// states and rejection of misaligned or out-of-range accesses.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        busy_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem_q [DEPTH];

  logic          accWe;
  logic [31:0]   accAddr;
  logic [31:0]   accWdata;
  logic [3:0]    accBe;
  logic          accErr;
  logic [AW-1:0] accIdx;
  logic          doAccess;
  logic          memWrite;

  // With zero latency the access happens on the accepting edge, so it must see
  // the live inputs; otherwise it uses the values latched at acceptance.
  always_comb begin
    accWe    = we_q;
    accAddr  = addr_q;
    accWdata = wdata_q;
    accBe    = be_q;
    if (state_q == IDLE) begin
      accWe    = we_i;
      accAddr  = addr_i;
      accWdata = wdata_i;
      accBe    = be_i;
    end
  end

  assign accErr   = (accAddr[1:0] != 2'b00) || (accAddr[31:2] >= 30'(DEPTH));
  assign accIdx   = accAddr[AW+1:2];
  assign doAccess = ((state_q == IDLE) && req_i && (LATENCY == 0)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd1));
  assign memWrite = doAccess && accWe && !accErr;

  // Storage is never cleared; the reset qualifier keeps an access from landing
  // on an edge where the controller is being held in reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (accBe[i]) mem_q[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            cnt_q   <= LAT;
            busy_q  <= (LATENCY != 0);
            state_q <= WAIT;
          end
        end
        WAIT: cnt_q <= cnt_q - 4'd1;
        ACK: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Completion overrides the per-state updates above.
      if (doAccess) begin
        busy_q  <= 1'b0;
        ack_q   <= 1'b1;
        err_q   <= accErr;
        state_q <= ACK;
        if (!accWe) rdata_q <= accErr ? 32'd0 : mem_q[accIdx];
      end
    end
  end

  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder: a LATENCY=2 instance checked
// against an array-based memory model, plus a LATENCY=0 instance for timing.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        reqA, weA, busyA, ackA, errA;
  logic [31:0] addrA, wdataA, rdataA;
  logic [3:0]  beA;
  logic        reqB, weB, busyB, ackB, errB;
  logic [31:0] addrB, wdataB, rdataB;
  logic [3:0]  beB;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] refMem [DEPTH];
  logic [31:0] lastRdataA;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqA), .we_i(weA), .addr_i(addrA),
    .wdata_i(wdataA), .be_i(beA), .busy_o(busyA), .ack_o(ackA),
    .rdata_o(rdataA), .err_o(errA)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .req_i(reqB), .we_i(weB), .addr_i(addrB),
    .wdata_i(wdataB), .be_i(beB), .busy_o(busyB), .ack_o(ackB),
    .rdata_o(rdataB), .err_o(errB)
  );

  // Reference model: a plain word array with byte-merge stores.
  function automatic void modelA(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] expRd, output logic expErr);
    int idx;
    expErr = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    idx    = int'(addr / 4);
    if (expErr) begin
      if (!we) lastRdataA = 32'd0;
    end else if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) refMem[idx][8*i +: 8] = wdata[8*i +: 8];
    end else begin
      lastRdataA = refMem[idx];
    end
    expRd = lastRdataA;
  endfunction

  // One handshake on instance A; scrambles the request fields while busy.
  task automatic transA(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int cycles, output logic busyE0,
                        output logic busyAtAck, output logic [31:0] rd, output logic er);
    @(negedge clk);
    weA = we; addrA = addr; wdataA = wdata; beA = be; reqA = 1'b1;
    cycles = 0; busyE0 = 1'b0; busyAtAck = 1'b1; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) busyE0 = busyA;
      if (ackA) begin
        cycles = k; busyAtAck = busyA; rd = rdataA; er = errA;
        break;
      end
      weA = 1'($urandom); addrA = $urandom; wdataA = $urandom; beA = 4'($urandom);
    end
    reqA = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busyA, ackA, errA, rdataA} !== 35'd0) begin
      mismatched++;
      $display("[TB] FAIL resetA: got busy=%b ack=%b err=%b rdata=%h want all 0", busyA, ackA, errA, rdataA);
    end
    compared++;
    if ({busyB, ackB, errB, rdataB} !== 35'd0) begin
      mismatched++;
      $display("[TB] FAIL resetB: got busy=%b ack=%b err=%b rdata=%h want all 0", busyB, ackB, errB, rdataB);
    end
    rst_n = 1'b1;
    lastRdataA = 32'd0;
  endtask

  task automatic test_init();
    int cyc; logic bE0, bAck, er, expErr; logic [31:0] rd, expRd, wd;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      modelA(1'b1, 32'(w * 4), wd, 4'hF, expRd, expErr);
      transA(1'b1, 32'(w * 4), wd, 4'hF, cyc, bE0, bAck, rd, er);
      compared++;
      if (cyc != LAT_A + 1 || er !== expErr) begin
        mismatched++;
        $display("[TB] FAIL init word %0d: got cycles=%0d err=%b want cycles=%0d err=%b", w, cyc, er, LAT_A + 1, expErr);
      end
    end
  endtask

  task automatic test_store_load();
    int cyc; logic bE0, bAck, er, expErr; logic [31:0] rd, expRd;
    modelA(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, expRd, expErr);
    transA(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, cyc, bE0, bAck, rd, er);
    compared++;
    if (bE0 !== 1'b1) begin mismatched++; $display("[TB] FAIL busy after E0: got %b want 1", bE0); end
    compared++;
    if (cyc != LAT_A + 1) begin mismatched++; $display("[TB] FAIL ack latency: got %0d want %0d", cyc, LAT_A + 1); end
    compared++;
    if (er !== 1'b0 || bAck !== 1'b0) begin
      mismatched++; $display("[TB] FAIL store ack flags: got err=%b busy=%b want 0 0", er, bAck);
    end
    modelA(1'b0, 32'h10, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h10, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (rd !== expRd || er !== expErr) begin
      mismatched++; $display("[TB] FAIL load 0x10: got %h err=%b want %h err=%b", rd, er, expRd, expErr);
    end
  endtask

  task automatic test_partial();
    int cyc; logic bE0, bAck, er, expErr; logic [31:0] rd, expRd;
    modelA(1'b1, 32'h10, 32'h000000AA, 4'b0001, expRd, expErr);
    transA(1'b1, 32'h10, 32'h000000AA, 4'b0001, cyc, bE0, bAck, rd, er);
    modelA(1'b0, 32'h10, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h10, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (rd !== 32'hDEADBEAA) begin mismatched++; $display("[TB] FAIL partial store: got %h want DEADBEAA", rd); end
    modelA(1'b1, 32'h10, 32'h11223344, 4'b0000, expRd, expErr);
    transA(1'b1, 32'h10, 32'h11223344, 4'b0000, cyc, bE0, bAck, rd, er);
    compared++;
    if (cyc != LAT_A + 1 || er !== 1'b0) begin
      mismatched++; $display("[TB] FAIL be=0 store: got cycles=%0d err=%b want %0d 0", cyc, er, LAT_A + 1);
    end
    modelA(1'b0, 32'h10, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h10, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (rd !== expRd) begin mismatched++; $display("[TB] FAIL after be=0: got %h want %h", rd, expRd); end
  endtask

  task automatic test_errors();
    int cyc; logic bE0, bAck, er, expErr; logic [31:0] rd, expRd;
    modelA(1'b0, 32'h13, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h13, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (er !== 1'b1 || rd !== 32'd0 || cyc != LAT_A + 1) begin
      mismatched++; $display("[TB] FAIL misaligned load: got err=%b rdata=%h cycles=%0d want 1 0 %0d", er, rd, cyc, LAT_A + 1);
    end
    modelA(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, expRd, expErr);
    transA(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, cyc, bE0, bAck, rd, er);
    compared++;
    if (er !== 1'b1) begin mismatched++; $display("[TB] FAIL out-of-range store: got err=%b want 1", er); end
    modelA(1'b0, 32'h0, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h0, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (rd !== expRd || er !== 1'b0) begin
      mismatched++; $display("[TB] FAIL load 0x0 after bad store: got %h err=%b want %h 0", rd, er, expRd);
    end
    modelA(1'b1, 32'h3FC, 32'h5A5AA5A5, 4'hF, expRd, expErr);
    transA(1'b1, 32'h3FC, 32'h5A5AA5A5, 4'hF, cyc, bE0, bAck, rd, er);
    modelA(1'b0, 32'h3FC, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h3FC, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (rd !== 32'h5A5AA5A5 || er !== 1'b0) begin
      mismatched++; $display("[TB] FAIL last word 0x3FC: got %h err=%b want 5a5aa5a5 0", rd, er);
    end
  endtask

  task automatic test_random();
    int cyc, r; logic bE0, bAck, er, expErr, we; logic [31:0] rd, expRd, addr, wd; logic [3:0] be;
    for (int n = 0; n < 40; n++) begin
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom); be = 4'($urandom); wd = $urandom;
      if (r == 0)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) addr = 32'h400 + $urandom;
      else             addr = 32'($urandom_range(0, 15) * 4);
      modelA(we, addr, wd, be, expRd, expErr);
      transA(we, addr, wd, be, cyc, bE0, bAck, rd, er);
      compared++;
      if (cyc != LAT_A + 1 || bE0 !== 1'b1 || er !== expErr || rd !== expRd) begin
        mismatched++;
        $display("[TB] FAIL random #%0d we=%b addr=%h: got cycles=%0d busy=%b err=%b rdata=%h want %0d 1 %b %h",
                 n, we, addr, cyc, bE0, er, rd, LAT_A + 1, expErr, expRd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks; int ackCyc[3]; logic [31:0] rdObs[3]; logic [31:0] expRd[3]; logic expErr;
    for (int j = 0; j < 3; j++) modelA(1'b0, 32'(j * 4), 32'h0, 4'h0, expRd[j], expErr);
    acks = 0;
    @(negedge clk);
    weA = 1'b0; addrA = 32'h0; beA = 4'h0; reqA = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ackA) begin
        if (acks < 3) begin ackCyc[acks] = k; rdObs[acks] = rdataA; end
        acks++;
        if (acks < 3) addrA = 32'(acks * 4);
        else reqA = 1'b0;
      end
    end
    reqA = 1'b0;
    compared++;
    if (acks != 3) begin mismatched++; $display("[TB] FAIL b2b ack count: got %0d want 3", acks); end
    else begin
      compared++;
      if (ackCyc[0] != LAT_A + 1 || ackCyc[1] - ackCyc[0] != LAT_A + 2 || ackCyc[2] - ackCyc[1] != LAT_A + 2) begin
        mismatched++;
        $display("[TB] FAIL b2b spacing: got acks at %0d %0d %0d want %0d then every %0d",
                 ackCyc[0], ackCyc[1], ackCyc[2], LAT_A + 1, LAT_A + 2);
      end
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (rdObs[j] !== expRd[j]) begin
          mismatched++; $display("[TB] FAIL b2b load %0d: got %h want %h", j, rdObs[j], expRd[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    int cyc, strayAcks; logic bE0, bAck, er, expErr; logic [31:0] rd, expRd;
    modelA(1'b1, 32'h20, 32'h0, 4'hF, expRd, expErr);
    transA(1'b1, 32'h20, 32'h0, 4'hF, cyc, bE0, bAck, rd, er);
    @(negedge clk);
    weA = 1'b1; addrA = 32'h20; wdataA = 32'h12345678; beA = 4'hF; reqA = 1'b1;
    @(negedge clk);
    compared++;
    if (busyA !== 1'b1) begin mismatched++; $display("[TB] FAIL midop busy before reset: got %b want 1", busyA); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (busyA !== 1'b0 || ackA !== 1'b0) begin
      mismatched++; $display("[TB] FAIL async reset: got busy=%b ack=%b want 0 0", busyA, ackA);
    end
    @(negedge clk);
    rst_n = 1'b1; reqA = 1'b0;
    lastRdataA = 32'd0;
    strayAcks = 0;
    repeat (6) begin @(negedge clk); if (ackA || busyA) strayAcks++; end
    compared++;
    if (strayAcks != 0) begin mismatched++; $display("[TB] FAIL aborted access resumed: got %0d active cycles want 0", strayAcks); end
    modelA(1'b0, 32'h20, 32'h0, 4'h0, expRd, expErr);
    transA(1'b0, 32'h20, 32'h0, 4'h0, cyc, bE0, bAck, rd, er);
    compared++;
    if (rd !== 32'h0) begin mismatched++; $display("[TB] FAIL aborted store landed: got %h want 00000000", rd); end
  endtask

  task automatic test_latency0();
    int acks, busySeen; logic [31:0] wd;
    logic pattern [10];
    wd = $urandom;
    @(negedge clk);
    weB = 1'b1; addrB = 32'h8; wdataB = wd; beB = 4'hF; reqB = 1'b1;
    @(negedge clk);
    compared++;
    if (ackB !== 1'b1 || busyB !== 1'b0 || errB !== 1'b0) begin
      mismatched++; $display("[TB] FAIL lat0 store: got ack=%b busy=%b err=%b want 1 0 0", ackB, busyB, errB);
    end
    reqB = 1'b0;
    @(negedge clk);
    compared++;
    if (ackB !== 1'b0) begin mismatched++; $display("[TB] FAIL lat0 ack width: got %b want 0", ackB); end
    weB = 1'b0; reqB = 1'b1;
    @(negedge clk);
    compared++;
    if (ackB !== 1'b1 || rdataB !== wd) begin
      mismatched++; $display("[TB] FAIL lat0 load: got ack=%b rdata=%h want 1 %h", ackB, rdataB, wd);
    end
    reqB = 1'b0;
    @(negedge clk);
    addrB = 32'h400; reqB = 1'b1;
    @(negedge clk);
    compared++;
    if (ackB !== 1'b1 || errB !== 1'b1 || rdataB !== 32'd0) begin
      mismatched++; $display("[TB] FAIL lat0 range error: got ack=%b err=%b rdata=%h want 1 1 0", ackB, errB, rdataB);
    end
    reqB = 1'b0;
    @(negedge clk);
    addrB = 32'h8; reqB = 1'b1;
    acks = 0; busySeen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pattern[k] = ackB;
      if (ackB) acks++;
      if (busyB) busySeen++;
    end
    reqB = 1'b0;
    compared++;
    if (acks != 5 || busySeen != 0) begin
      mismatched++; $display("[TB] FAIL lat0 rate: got acks=%0d busy cycles=%0d want 5 0", acks, busySeen);
    end
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (pattern[k] !== 1'((k + 1) % 2)) begin
        mismatched++; $display("[TB] FAIL lat0 pattern cycle %0d: got ack=%b want %b", k, pattern[k], 1'((k + 1) % 2));
      end
    end
  endtask

  initial begin
    reqA = 1'b0; weA = 1'b0; addrA = 32'd0; wdataA = 32'd0; beA = 4'd0;
    reqB = 1'b0; weB = 1'b0; addrB = 32'd0; wdataB = 32'd0; beB = 4'd0;
    rst_n = 1'b1;
    lastRdataA = 32'd0;
    #2;
    test_reset();
    test_init();
    test_store_load();
    test_partial();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_latency0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
